// File: rtl/flt2int_fsm.sv
// rtl/flt2int_fsm.sv - half-precision float to saturating int16 memory-to-memory sequencer
module flt2int_fsm #(
  parameter logic [7:0] IN_ADDR  = 8'd4,
  parameter logic [7:0] OUT_ADDR = 8'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, LD_HI, LD_LO, CLASSIFY, SHIFT, NEG, ST_HI, ST_LO
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] f;
  logic [15:0] mag;
  logic [3:0]  cnt;
  logic        shl;

  logic       s;
  logic [4:0] e;
  logic [9:0] m;

  assign s = f[15];
  assign e = f[14:10];
  assign m = f[9:0];

  always_comb begin
    state_nxt = state;
    mem_addr  = 8'd0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'd0;
    case (state)
      IDLE:     if (start) state_nxt = LD_HI;
      LD_HI: begin
        mem_addr  = IN_ADDR;
        mem_rd    = 1'b1;
        state_nxt = LD_LO;
      end
      LD_LO: begin
        mem_addr  = IN_ADDR + 8'd1;
        mem_rd    = 1'b1;
        state_nxt = CLASSIFY;
      end
      CLASSIFY: begin
        // e of 30/31 always ends in a saturated or exact 0x8000 result
        if (e >= 5'd30)                     state_nxt = ST_HI;
        else if (e < 5'd15 || e == 5'd25)   state_nxt = NEG;
        else                                state_nxt = SHIFT;
      end
      SHIFT:    if (cnt == 4'd1) state_nxt = NEG;
      NEG:      state_nxt = ST_HI;
      ST_HI: begin
        mem_addr  = OUT_ADDR;
        mem_wr    = 1'b1;
        mem_wdata = mag[15:8];
        state_nxt = ST_LO;
      end
      ST_LO: begin
        mem_addr  = OUT_ADDR + 8'd1;
        mem_wr    = 1'b1;
        mem_wdata = mag[7:0];
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
      f     <= 16'd0;
      mag   <= 16'd0;
      cnt   <= 4'd0;
      shl   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:  if (start) done <= 1'b0;
        LD_HI: f[15:8] <= mem_rdata;
        LD_LO: f[7:0]  <= mem_rdata;
        CLASSIFY: begin
          if (e < 5'd15) begin
            mag <= 16'd0;
            cnt <= 4'd0;
          end else if (e >= 5'd30) begin
            mag <= s ? 16'h8000 : 16'h7FFF;
            cnt <= 4'd0;
          end else begin
            mag <= {5'b0, 1'b1, m};
            if (e > 5'd25) begin
              cnt <= 4'(e - 5'd25);
              shl <= 1'b1;
            end else begin
              cnt <= 4'(5'd25 - e);
              shl <= 1'b0;
            end
          end
        end
        SHIFT: begin
          mag <= shl ? (mag << 1) : (mag >> 1);
          cnt <= cnt - 4'd1;
        end
        NEG:   if (s) mag <= ~mag + 16'd1;
        ST_LO: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/flt2int_fsm.md
# flt2int_fsm

Hardware sequencer performing the inverse of the integer-to-float program: reads a 16-bit half-precision float from data memory, converts it to a 16-bit two's-complement integer (truncation toward zero, saturating), and writes the result back to data memory. It uses the same `start`/`done` handshake as the processor top level and drives a single-port data-memory interface equivalent to the one `data_mem` exposes. It is a drop-in alternative to running the float-to-integer program on the core.

## Interface
- `IN_ADDR`, default 8'd4: address of the float's high byte; the low byte is at `IN_ADDR+1`.
- `OUT_ADDR`, default 8'd6: address of the result's high byte; the low byte is at `OUT_ADDR+1`.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `start`  input  1  level sampled in IDLE only; starts one conversion.
- `mem_rdata`  input  8  data-memory read data; combinational with respect to `mem_addr`.
- `mem_addr`  output  8  data-memory address.
- `mem_rd`  output  1  read enable.
- `mem_wr`  output  1  write enable; memory writes on the `clk` edge.
- `mem_wdata`  output  8  write data.
- `done`  output  1  registered; high from conversion completion until the next accepted `start`.

## Operation
- Float format: bit 15 is the sign `s`, bits 14:10 are the exponent `e` (bias 15), bits 9:0 are the mantissa `m` with an implicit leading 1. Memory byte order is big-endian: the high byte is at the lower address.
- States: IDLE, LD_HI, LD_LO, CLASSIFY, SHIFT, NEG, ST_HI, ST_LO.
- **IDLE:** on `start`=1, go to LD_HI and clear `done`.
- **LD_HI:** `mem_addr`=IN_ADDR, `mem_rd`=1. Capture `mem_rdata` into `f[15:8]`.
- **LD_LO:** `mem_addr`=IN_ADDR+1, `mem_rd`=1. Capture `f[7:0]`.
- **CLASSIFY:** set the 16-bit magnitude `mag` and the shift count according to the first matching rule:
  - `e`<15 (covers zero and subnormals): `mag`=0.
  - `e`==31 (Inf/NaN), or `e`==30 with not (`s`=1 and `m`=0): result saturates to 0x7FFF if `s`=0, 0x8000 if `s`=1. Skip NEG.
  - `e`==30, `m`=0, `s`=1: result is exactly 0x8000. Skip NEG.
  - Otherwise: `mag`={5'b0,1'b1,`m`}. Shift left by `e`-25 if `e`>25, right by 25-`e` if `e`<25. Right shifts discard bits (truncation).
  - Shift count 0: go to NEG. Otherwise go to SHIFT.
- **SHIFT:** one 1-bit shift per cycle, with a 4-bit down-counter. Leave when the counter reaches 0. Maximum is 10 right shifts (`e`=15) or 4 left shifts (`e`=29).
- **NEG:** if `s`=1, `mag` becomes `~mag+1`. A zero magnitude stays 0x0000 (no negative zero).
- **ST_HI:** `mem_addr`=OUT_ADDR, `mem_wr`=1, `mem_wdata`=`mag[15:8]`.
- **ST_LO:** `mem_addr`=OUT_ADDR+1, `mem_wr`=1, `mem_wdata`=`mag[7:0]`. Go to IDLE and set `done`=1.
- Memory outputs are decoded from state only. In IDLE, CLASSIFY, SHIFT and NEG: `mem_rd`=`mem_wr`=0 and `mem_addr`=`mem_wdata`=0.
- `start` outside IDLE is ignored. `start` held high in IDLE retriggers a new conversion every pass.
- Saturated or exact-0x8000 results go from CLASSIFY directly to ST_HI.

## Timing
- Reset (`reset`=0 at an edge): state=IDLE, `done`=0, `f`=0, `mag`=0, counter=0. All memory outputs are 0 in the following cycle.
- Reset mid-operation aborts the conversion:
  - no write occurs after the reset edge;
  - a byte already written by ST_HI stays in memory;
  - `done` stays 0 until a later conversion completes.
- Latency from the edge that samples `start` to the edge that sets `done`:
  - normal path: 6+N cycles, where N is the shift count (0..10);
  - saturated or 0x8000 path: 5 cycles.
- `done` is high in the cycle after ST_LO and falls on the edge that accepts the next `start`.

## Test plan
- **Exact conversions:** 0x3C00 (1.0) → mem[6:7]=0x00,0x01, `done` 16 cycles after `start`. 0x6400 (1024.0) → 0x0400, `done` at 6 cycles. 0x7000 (8192.0) → 0x2000, `done` at 9 cycles.
- **Negative and truncation:** 0xC500 (-5.0) → 0xFFFB. 0x4A00 (12.0) → 0x000C. 0x3E00 (1.5) → 0x0001. 0xBE00 (-1.5) → 0xFFFF.
- **Saturation:** 0x7BFF (65504) → 0x7FFF. 0xFBFF → 0x8000. 0xF800 (-32768) → 0x8000. 0x7C00 (+Inf) → 0x7FFF. 0xFE00 (NaN, s=1) → 0x8000. Each path has `done` at 5 cycles.
- **Small and zero:** 0x3BFF → 0x0000. 0x8000 (-0) → 0x0000. 0x0001 (subnormal) → 0x0000. 0xB800 (-0.5) → 0x0000.
- **Handshake:**
  - `start` pulsed during SHIFT is ignored and exactly two writes occur;
  - `start` held high produces back-to-back conversions;
  - the bus shows `mem_rd` only at addresses 4 and 5, and `mem_wr` only at addresses 6 and 7.
- **Reset mid-operation:** `reset`=0 during SHIFT for 0x3C00 → no writes, mem[6:7] keeps its preload 0xAA,0xAA, `done`=0. A following `start` converts correctly.
